heartbeat_sequencer: RTL and testbench
======================================

# heartbeat_sequencer

Controller for the DE1-SoC board heartbeat LED. It divides CLOCK_50 into a slow tick and runs a four-phase "lub-dub" beat sequence (BEAT1, GAP, BEAT2, REST) on LEDR[0]. Beat rate is adjustable and the beat can be paused, both from debounced push-buttons. Current rate, pause status and phase are also shown on LEDR. It sits directly under the board top level, driven by CLOCK_50 and KEY.

## Interface
- TICK_DIV, 500000: CLOCK_50 cycles per tick (10 ms at 50 MHz). Must be ≥ 2.
- DEB_TICKS, 2: consecutive ticks a synchronised key must differ from its debounced level before that level flips.
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- KEY  in  4  active-low buttons:
  - KEY[0] is the asynchronous active-low reset.
  - KEY[1] = rate up, KEY[2] = rate down, KEY[3] = pause toggle.
- LEDR  out  10  all bits registered:
  - [0] beat
  - [4:2] rate
  - [5] paused
  - [8:6] state code
  - [9] tick toggle
  - [1] constant 0

## Operation
- **Prescaler:** counter 0..TICK_DIV-1, width $clog2(TICK_DIV). A one-cycle `tick` pulses when count = TICK_DIV-1, then the counter wraps to 0. LEDR[9] toggles on every tick. The prescaler runs even while paused.
- **Keys KEY[3:1]:**
  - Each key passes through a 2-FF synchroniser, then a debouncer evaluated on tick only.
  - A per-key stability counter increments on tick while synced ≠ debounced, and clears whenever they are equal.
  - The debounced level flips when the counter reaches DEB_TICKS.
  - A press is a one-cycle pulse on the debounced 1→0 edge.
  - Debounced levels reset to 1.
- **Rate (3-bit, reset 3):**
  - Up press: +1, saturating at 7. Down press: -1, saturating at 0.
  - Up and down press in the same cycle: no change.
- **Pause (reset 0):** KEY[3] press toggles it. While paused:
  - state and phase counter are frozen;
  - LEDR[0] holds its value;
  - rate changes are still accepted.
- **FSM states and codes:** IDLE=0, BEAT1=1, GAP=2, BEAT2=3, REST=4. Codes 5-7 are illegal and recover to IDLE.
  - IDLE→BEAT1 on the first unpaused tick.
  - BEAT1 lasts 8 ticks, GAP 12 ticks, BEAT2 8 ticks, REST 16·(8−rate) ticks (128 ticks at rate 0, 16 at rate 7).
  - REST→BEAT1.
- **Phase counter (7 bits):**
  - Counts unpaused ticks. On the tick where count = duration−1, the FSM advances and the counter clears.
  - REST duration is latched from rate on entry to REST. A rate change takes effect at the next REST.
- **LEDR[0]** = 1 in BEAT1 and BEAT2, else 0.

## Timing
- Reset (KEY[0]=0, asynchronous): LEDR = 10'b00_0000_1100. That is rate 3, state IDLE, all other bits 0. All counters clear and debounced levels go to 1.
- State, rate, paused and LEDR update on the same edge, all driven from next-state values. There is no extra output latency.
- Key-to-effect latency: 2 synchroniser cycles, plus DEB_TICKS ticks, plus 1 cycle (press pulse registered, then rate/pause update).
- Pause and FSM advance on the same tick: pause wins, and the FSM stays in its current phase.
- Period at rate r: (28 + 16·(8−r))·TICK_DIV cycles.

## Structure
- Package heartbeat_pkg holds:
  - the state enum and codes;
  - constants BEAT_TICKS=8, GAP_TICKS=12, REST_UNIT=16, RATE_RESET=3'd3;
  - the LEDR field index constants.
- Sub-module key_debouncer (synchroniser, stability counter, press pulse) is instantiated three times. Its ports are CLOCK_50, reset_n, tick, key_in, level, press.
- Top holds the prescaler, rate/pause registers, FSM, phase counter and LEDR register.

## Test plan
Sim parameters: TICK_DIV=4, DEB_TICKS=2.
- **Reset:** hold KEY[0]=0 → LEDR = 0000001100. Release → 4 cycles later LEDR[0]=1, LEDR[8:6]=001, LEDR[9]=1.
- **Default sequence:** LEDR[0] high 32 cycles, low 48, high 32, low 320. Period 432 cycles, repeating.
- **Rate limits:**
  - KEY[1] held low 20 cycles → LEDR[4:2]=100. Five more presses → 111, and the next REST lasts 64 cycles.
  - Eight KEY[2] presses → 000.
- **Debounce:** KEY[1] low for 5 cycles (less than 2 ticks stable) → rate unchanged. A simultaneous clean press of KEY[1] and KEY[2] → unchanged.
- **Pause:**
  - KEY[3] press in GAP tick 5 → LEDR[5]=1 and state 010 for 200 cycles, while LEDR[9] keeps toggling.
  - Second press → exactly 7 more GAP ticks, then BEAT2.
- **Reset mid-operation:** KEY[0] pulsed low during BEAT2 with rate 6 and paused → LEDR = 0000001100 immediately, with no clock edge required.

Source files
------------

// File: rtl/heartbeat_pkg.sv
// Shared types and constants for the heartbeat LED sequencer.
// Holds the beat-phase encoding, phase lengths and LEDR field positions.
package heartbeat_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StBeat1 = 3'd1,
        StGap   = 3'd2,
        StBeat2 = 3'd3,
        StRest  = 3'd4
    } hb_state_e;

    localparam int unsigned BEAT_TICKS = 8;
    localparam int unsigned GAP_TICKS  = 12;
    localparam int unsigned REST_UNIT  = 16;
    localparam logic [2:0]  RATE_RESET = 3'd3;

    localparam int unsigned LED_BEAT     = 0;
    localparam int unsigned LED_RATE_LO  = 2;
    localparam int unsigned LED_RATE_HI  = 4;
    localparam int unsigned LED_PAUSED   = 5;
    localparam int unsigned LED_STATE_LO = 6;
    localparam int unsigned LED_STATE_HI = 8;
    localparam int unsigned LED_TICK     = 9;

    localparam logic [9:0] LEDR_RESET = 10'b00_0000_1100;

    // Last phase-counter value of REST: 16*(8-rate)-1, i.e. 127 at rate 0 down to 15 at rate 7.
    function automatic logic [6:0] rest_last(input logic [2:0] rate);
        logic [7:0] len;
        len = 8'(REST_UNIT) * (8'd8 - {5'd0, rate});
        return 7'(len - 8'd1);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, tick-sampled stability counter and
// a one-cycle press pulse on the debounced falling edge.
module key_debouncer
    import heartbeat_pkg::*;
#(
    parameter int unsigned DEB_TICKS = 2
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic tick,
    input  logic key_in,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEB_TICKS + 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CntW'(DEB_TICKS - 1)) begin
                cnt_d   = '0;
                level_d = sync2_q;
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/heartbeat_sequencer.sv
// DE1-SoC heartbeat LED controller: prescaler, key-driven rate/pause and the
// four-phase lub-dub sequence, all reported on a fully registered LEDR.
module heartbeat_sequencer
    import heartbeat_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 500000,
    parameter int unsigned DEB_TICKS = 2
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    output logic [9:0] LEDR
);

    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic            rst_n;
    logic [DivW-1:0] div_q, div_d;
    logic            tick;
    logic [2:0]      key_level, key_press;
    logic            up_evt, dn_evt, pause_evt;
    logic [2:0]      rate_q, rate_d;
    logic            paused_q, paused_d;
    hb_state_e       state_q, state_d;
    logic [6:0]      phase_q, phase_d, phase_last;
    logic [6:0]      rest_last_q, rest_last_d;
    logic            run;
    logic [9:0]      ledr_q, ledr_d;

    assign rst_n = KEY[0];

    assign tick  = (div_q == DivW'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + DivW'(1);

    key_debouncer #(.DEB_TICKS(DEB_TICKS)) u_key_up (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (rst_n),
        .tick     (tick),
        .key_in   (KEY[1]),
        .level    (key_level[0]),
        .press    (key_press[0])
    );

    key_debouncer #(.DEB_TICKS(DEB_TICKS)) u_key_down (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (rst_n),
        .tick     (tick),
        .key_in   (KEY[2]),
        .level    (key_level[1]),
        .press    (key_press[1])
    );

    key_debouncer #(.DEB_TICKS(DEB_TICKS)) u_key_pause (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (rst_n),
        .tick     (tick),
        .key_in   (KEY[3]),
        .level    (key_level[2]),
        .press    (key_press[2])
    );

    // A press always coincides with a low debounced level; the AND just keeps both in use.
    assign up_evt    = key_press[0] & ~key_level[0];
    assign dn_evt    = key_press[1] & ~key_level[1];
    assign pause_evt = key_press[2] & ~key_level[2];

    always_comb begin
        rate_d = rate_q;
        if (up_evt && !dn_evt && (rate_q != 3'd7)) begin
            rate_d = rate_q + 3'd1;
        end else if (dn_evt && !up_evt && (rate_q != 3'd0)) begin
            rate_d = rate_q - 3'd1;
        end
    end

    assign paused_d = paused_q ^ pause_evt;
    assign run      = tick & ~paused_d;

    always_comb begin
        phase_last = '0;
        case (state_q)
            StBeat1: phase_last = 7'(BEAT_TICKS - 1);
            StGap:   phase_last = 7'(GAP_TICKS - 1);
            StBeat2: phase_last = 7'(BEAT_TICKS - 1);
            StRest:  phase_last = rest_last_q;
            default: phase_last = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rest_last_d = rest_last_q;
        case (state_q)
            StIdle, StBeat1, StGap, StBeat2, StRest: begin
                if (run) begin
                    if (phase_q == phase_last) begin
                        phase_d = '0;
                        case (state_q)
                            StIdle:  state_d = StBeat1;
                            StBeat1: state_d = StGap;
                            StGap:   state_d = StBeat2;
                            StBeat2: begin
                                state_d     = StRest;
                                rest_last_d = rest_last(rate_q);
                            end
                            default: state_d = StBeat1;
                        endcase
                    end else begin
                        phase_d = phase_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        ledr_d = '0;
        ledr_d[LED_BEAT]                  = (state_d == StBeat1) || (state_d == StBeat2);
        ledr_d[LED_RATE_HI:LED_RATE_LO]   = rate_d;
        ledr_d[LED_PAUSED]                = paused_d;
        ledr_d[LED_STATE_HI:LED_STATE_LO] = state_d;
        ledr_d[LED_TICK]                  = ledr_q[LED_TICK] ^ tick;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            rate_q      <= RATE_RESET;
            paused_q    <= 1'b0;
            state_q     <= StIdle;
            phase_q     <= '0;
            rest_last_q <= '0;
            ledr_q      <= LEDR_RESET;
        end else begin
            div_q       <= div_d;
            rate_q      <= rate_d;
            paused_q    <= paused_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            rest_last_q <= rest_last_d;
            ledr_q      <= ledr_d;
        end
    end

    assign LEDR = ledr_q;

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// Directed bench for heartbeat_sequencer: a table of LEDR segments for the default
// beat, then hand-written rate, debounce, pause and asynchronous-reset sequences.
module tb_heartbeat_sequencer;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] ledr;
    logic [9:0] prev_ledr;
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    heartbeat_sequencer #(.TICK_DIV(4), .DEB_TICKS(2)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .LEDR     (ledr)
    );

    typedef struct {
        logic [3:0] key;
        int         cycles;
        logic [9:0] exp;
        logic [9:0] mask;
        string      name;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        prev_ledr = ledr;
        @(posedge clk);
        #1;
    endtask

    function automatic bit tog();
        return ledr[9] != prev_ledr[9];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic wait_code(input logic [2:0] code, input bit want_eq, input string name);
        int c = 0;
        while (((ledr[8:6] == code) != want_eq) && (c < 3000)) begin
            step();
            c++;
        end
        if (c >= 3000) begin
            checks++;
            $display("FAIL %s: timeout after %0d cycles waiting on state %0d", name, c, code);
        end
    endtask

    task automatic press(input int idx);
        key[idx] = 1'b0;
        repeat (20) step();
        key[idx] = 1'b1;
        repeat (20) step();
    endtask

    initial begin
        int n;
        int c;
        int bad;
        int tcount;
        logic [9:0] first_bad;

        vecs[0] = '{4'b1110, 3,   10'b00_0000_1100, 10'h3FF, "reset held"};
        vecs[1] = '{4'b1111, 3,   10'b00_0000_1100, 10'h3FF, "idle before first tick"};
        vecs[2] = '{4'b1111, 1,   10'b10_0100_1101, 10'h3FF, "first tick enters beat1"};
        vecs[3] = '{4'b1111, 31,  10'b00_0100_1101, 10'h1FF, "beat1 rest of 32"};
        vecs[4] = '{4'b1111, 48,  10'b00_1000_1100, 10'h1FF, "gap 48"};
        vecs[5] = '{4'b1111, 32,  10'b00_1100_1101, 10'h1FF, "beat2 32"};
        vecs[6] = '{4'b1111, 320, 10'b01_0000_1100, 10'h1FF, "rest 320 at rate 3"};
        vecs[7] = '{4'b1111, 32,  10'b00_0100_1101, 10'h1FF, "beat1 second period"};

        key = 4'b1111;
        prev_ledr = '0;
        #3 key[0] = 1'b0;
        #1 check("async reset value", int'(ledr), int'(10'b00_0000_1100));

        for (int v = 0; v < 8; v++) begin
            bad = 0;
            first_bad = '0;
            key = vecs[v].key;
            for (int k = 0; k < vecs[v].cycles; k++) begin
                step();
                if (((ledr ^ vecs[v].exp) & vecs[v].mask) != 10'd0) begin
                    if (bad == 0) first_bad = ledr;
                    bad++;
                end
            end
            checks++;
            if (bad == 0) passed++;
            else $display("FAIL %s: LEDR=%b expected %b mask %b (%0d bad cycles)",
                          vecs[v].name, first_bad, vecs[v].exp, vecs[v].mask, bad);
        end

        // Rate limits.
        press(1);
        check("rate after one up press", int'(ledr[4:2]), 4);
        repeat (5) press(1);
        check("rate saturates at 7", int'(ledr[4:2]), 7);
        wait_code(3'd4, 1'b0, "leave rest");
        wait_code(3'd4, 1'b1, "enter rest");
        n = 0;
        while ((ledr[8:6] == 3'd4) && (n < 3000)) begin
            step();
            n++;
        end
        check("rest length at rate 7", n, 64);
        repeat (8) press(2);
        check("rate saturates at 0", int'(ledr[4:2]), 0);

        // Short glitch aligned just after a tick sees only one tick of stability.
        c = 0;
        step();
        while (!tog() && (c < 10)) begin
            step();
            c++;
        end
        key[1] = 1'b0;
        repeat (5) step();
        key[1] = 1'b1;
        repeat (20) step();
        check("glitch ignored", int'(ledr[4:2]), 0);

        key[1] = 1'b0;
        key[2] = 1'b0;
        repeat (20) step();
        key[1] = 1'b1;
        key[2] = 1'b1;
        repeat (20) step();
        check("simultaneous up and down", int'(ledr[4:2]), 0);

        // Pause mid-GAP: key dropped right after the 3rd GAP tick lands after the 5th.
        wait_code(3'd2, 1'b0, "leave gap");
        wait_code(3'd2, 1'b1, "enter gap");
        n = 0;
        c = 0;
        while ((n < 3) && (c < 100)) begin
            step();
            c++;
            if (tog()) n++;
        end
        key[3] = 1'b0;
        c = 0;
        while (!ledr[5] && (c < 100)) begin
            step();
            c++;
            if (tog()) n++;
        end
        check("gap ticks before pause", n, 5);
        key[3] = 1'b1;
        bad = 0;
        tcount = 0;
        repeat (200) begin
            step();
            if ((ledr[8:6] != 3'd2) || !ledr[5] || ledr[0]) bad++;
            if (tog()) tcount++;
        end
        check("frozen in gap while paused", bad, 0);
        check("tick toggles while paused", tcount, 50);

        key[3] = 1'b0;
        n = 0;
        c = 0;
        while ((ledr[8:6] == 3'd2) && (c < 600)) begin
            step();
            c++;
            if (c == 20) key[3] = 1'b1;
            if (tog() && (prev_ledr[8:6] == 3'd2) && !prev_ledr[5]) n++;
        end
        key[3] = 1'b1;
        check("gap ticks after resume", n, 7);
        check("state after gap", int'(ledr[8:6]), 3);
        check("unpaused after second press", int'(ledr[5]), 0);
        repeat (20) step();

        // Rate 6, paused in BEAT2, then reset without a clock edge.
        repeat (6) press(1);
        wait_code(3'd3, 1'b0, "leave beat2");
        wait_code(3'd3, 1'b1, "enter beat2");
        press(3);
        check("paused in beat2 at rate 6", int'(ledr[8:0]), int'(9'b011_1_110_0_1));
        #2 key[0] = 1'b0;
        #1 check("async reset mid-operation", int'(ledr), int'(10'b00_0000_1100));
        repeat (2) step();
        key[0] = 1'b1;
        repeat (2) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
